// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl
// ----------------
// March C- memory BIST sequencer for a single-port synchronous SRAM with a
// 1-cycle read latency. On start it takes over the memory port (NbarT=1) and
// runs the six elements
//   E0 up(w0)  E1 up(r0,w1)  E2 up(r1,w0)  E3 dn(r0,w1)  E4 dn(r1,w0)  E5 dn(r0)
// with one op per cycle (10*DEPTH cycles). Each read is compared one cycle
// later against the background value registered alongside it.
//
// Optional feature: define MBIST_STOP_ON_FAIL_EN to abort the test on the
// first mismatch (straight to DONE, no further memory ops).
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   start           level request, sampled in IDLE and DONE
//   mem_rdata       SRAM read data, valid the cycle after re
//   NbarT           1 while BIST owns the memory (RUN, DRAIN)
//   addr/wdata      memory address / write data (0 outside RUN)
//   we/re           write / read strobes (0 outside RUN)
//   done            high in DONE
//   fail            sticky mismatch flag
//   fail_addr       address of the first mismatch
//   fail_cnt        saturating mismatch count
module mbist_march_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              NbarT,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              we,
    output logic              re,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [CNT_W-1:0]  fail_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    state_t            state_q, state_d;
    logic [2:0]        elem_q, elem_d;
    logic              op_q, op_d;           // op index within the element at one address
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_pend_q, rd_pend_d; // a read was issued last cycle
    logic              rd_bg_q, rd_bg_d;     // background expected for that read
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              fail_q, fail_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;

    logic run, two_ops, elem_up, op_rd, op_bg, addr_last, mismatch;

    // Decode the current op from (element, op index).
    always_comb begin
        two_ops = elem_q inside {3'd1, 3'd2, 3'd3, 3'd4};
        elem_up = (elem_q <= 3'd2);
        op_rd   = 1'b0;
        op_bg   = 1'b0;
        if (!two_ops) begin
            op_rd = (elem_q == 3'd5);          // E0 is w0, E5 is r0
        end else begin
            op_rd = !op_q;                     // read first, then write
            // E1/E3: r0 then w1; E2/E4: r1 then w0
            op_bg = (elem_q == 3'd1 || elem_q == 3'd3) ? op_q : !op_q;
        end
        addr_last = elem_up ? (addr_q == ADDR_MAX) : (addr_q == '0);
        mismatch  = rd_pend_q && (mem_rdata != {DATA_W{rd_bg_q}});
    end

    assign run       = (state_q == S_RUN);
    assign NbarT     = run || (state_q == S_DRAIN);
    assign addr      = run ? addr_q : '0;
    assign we        = run && !op_rd;
    assign re        = run && op_rd;
    assign wdata     = (run && !op_rd) ? {DATA_W{op_bg}} : '0;
    assign done      = (state_q == S_DONE);
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_cnt  = fail_cnt_q;

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        op_d        = op_q;
        addr_d      = addr_q;
        rd_pend_d   = re;
        rd_bg_d     = op_bg;
        rd_addr_d   = addr_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_cnt_d  = fail_cnt_q;

        if (mismatch) begin
            fail_d = 1'b1;
            if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
            if (!fail_q) fail_addr_d = rd_addr_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RUN;
                    elem_d      = 3'd0;
                    op_d        = 1'b0;
                    addr_d      = '0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_cnt_d  = '0;
                end
            end
            S_RUN: begin
                if (two_ops && !op_q) begin
                    op_d = 1'b1;
                end else begin
                    op_d = 1'b0;
                    if (addr_last) begin
                        if (elem_q == 3'd5) begin
                            state_d = S_DRAIN;
                        end else begin
                            elem_d = elem_q + 3'd1;
                            // E1,E2 start at the bottom; E3..E5 at the top
                            addr_d = (elem_q < 3'd2) ? '0 : ADDR_MAX;
                        end
                    end else begin
                        addr_d = elem_up ? addr_q + 1'b1 : addr_q - 1'b1;
                    end
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE: begin
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef MBIST_STOP_ON_FAIL_EN
        // Abort on the first mismatch; a read still in flight is dropped.
        if (mismatch) begin
            state_d   = S_DONE;
            rd_pend_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            elem_q      <= 3'd0;
            op_q        <= 1'b0;
            addr_q      <= '0;
            rd_pend_q   <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            rd_pend_q   <= rd_pend_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    // Read tag is only consulted when rd_pend_q is set, so it needs no reset.
    always_ff @(posedge clk) begin
        rd_bg_q   <= rd_bg_d;
        rd_addr_q <= rd_addr_d;
    end

endmodule
